spi_segment_frame_rx: RTL and testbench



---
 rtl/spi_segment_frame_rx_if.sv | 21 ++
 rtl/spi_segment_frame_rx.sv | 137 +++++++++++++
 tb/tb_spi_segment_frame_rx.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_segment_frame_rx_if.sv
// SPI pin bundle between an external SPI master and the segment frame receiver.
interface spi_segment_frame_rx_if;
    logic spi_sclk;
    logic spi_mosi;
    logic spi_cs_n;
    logic spi_miso;

    modport master (
        output spi_sclk,
        output spi_mosi,
        output spi_cs_n,
        input  spi_miso
    );

    modport slave (
        input  spi_sclk,
        input  spi_mosi,
        input  spi_cs_n,
        output spi_miso
    );
endinterface

// File: rtl/spi_segment_frame_rx.sv
// SPI mode-0 slave receiving 16-bit command frames that update a held segment pattern.
// Optional SPI_SEG_READBACK_EN returns the held display state on MISO during each frame.
module spi_segment_frame_rx #(
    parameter logic [6:0] SEG_RESET   = 7'b0000000,
    parameter logic       BLANK_RESET = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ena,
    spi_segment_frame_rx_if.slave        spi,
    output logic [6:0]                   seg_o,
    output logic                         dp_o,
    output logic                         blank_o,
    output logic                         upd_o,
    output logic                         err_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // [0],[1] synchronize; [2] is the history flop for edge detection
    logic [2:0]  sclk_q;
    logic [2:0]  cs_q;
    logic [2:0]  mosi_q;
    logic [1:0]  state;
    logic [4:0]  bitcnt;
    logic [15:0] sr;
    logic        sclk_rise;
    logic        cs_fall;
    logic        cs_rise;
    logic        frame_start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q <= 3'b000;
            cs_q   <= 3'b111;
            mosi_q <= 3'b000;
        end else begin
            sclk_q <= {sclk_q[1:0], spi.spi_sclk};
            cs_q   <= {cs_q[1:0],   spi.spi_cs_n};
            mosi_q <= {mosi_q[1:0], spi.spi_mosi};
        end
    end

    assign sclk_rise   = sclk_q[1] & ~sclk_q[2];
    assign cs_fall     = ~cs_q[1] & cs_q[2];
    assign cs_rise     = cs_q[1] & ~cs_q[2];
    assign frame_start = (state == ST_IDLE) && cs_fall && ena;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            bitcnt  <= '0;
            sr      <= '0;
            seg_o   <= SEG_RESET;
            dp_o    <= 1'b0;
            blank_o <= BLANK_RESET;
            upd_o   <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            upd_o <= 1'b0;
            err_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (frame_start) begin
                        bitcnt <= '0;
                        sr     <= '0;
                        state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (!ena) begin
                        state <= ST_IDLE;
                    end else begin
                        // mosi_q[2] is the MOSI sample aligned with the sclk edge being acted on
                        if (sclk_rise) begin
                            sr <= {sr[14:0], mosi_q[2]};
                            if (bitcnt != 5'd17)
                                bitcnt <= bitcnt + 5'd1;
                        end
                        if (cs_rise)
                            state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    if (bitcnt == 5'd16) begin
                        case (sr[15:8])
                            8'h01: begin
                                seg_o <= sr[6:0];
                                dp_o  <= sr[7];
                                upd_o <= 1'b1;
                            end
                            8'h02: begin
                                blank_o <= sr[0];
                                upd_o   <= 1'b1;
                            end
                            8'h03: begin
                                seg_o   <= '0;
                                dp_o    <= 1'b0;
                                blank_o <= 1'b1;
                                upd_o   <= 1'b1;
                            end
                            default: err_o <= 1'b1;
                        endcase
                    end else begin
                        err_o <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef SPI_SEG_READBACK_EN
    logic [15:0] tx;
    logic        sclk_fall;

    assign sclk_fall = ~sclk_q[1] & sclk_q[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tx <= '0;
        else if (frame_start)
            tx <= {1'b0, blank_o, 6'b000000, dp_o, seg_o};
        else if ((state == ST_SHIFT) && sclk_fall)
            tx <= {tx[14:0], 1'b0};
    end

    // Gated by registered state and synced cs_n only, so no pin-to-output path
    assign spi.spi_miso = tx[15] & (state == ST_SHIFT) & ~cs_q[1];
`else
    assign spi.spi_miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_segment_frame_rx.sv
// Randomized self-checking bench for spi_segment_frame_rx against a frame-level model.
module tb_spi_segment_frame_rx;

    typedef struct {
        int       cyc;
        bit       upd;
        bit       err;
        logic [6:0] seg;
        logic     dp;
        logic     blank;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [6:0] seg_o;
    logic       dp_o;
    logic       blank_o;
    logic       upd_o;
    logic       err_o;

    spi_segment_frame_rx_if bus();

    spi_segment_frame_rx #(
        .SEG_RESET   (7'h00),
        .BLANK_RESET (1'b1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .spi     (bus),
        .seg_o   (seg_o),
        .dp_o    (dp_o),
        .blank_o (blank_o),
        .upd_o   (upd_o),
        .err_o   (err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Frame-level model, advanced by the driver as each frame is sent
    logic [6:0] m_seg   = 7'h00;
    logic       m_dp    = 1'b0;
    logic       m_blank = 1'b1;
    ev_t        q[$];

`ifdef SPI_SEG_READBACK_EN
    logic [15:0] rb_last = '0;
`endif

    // Output-side view of the model, advanced by the compare process when an event is due
    logic [6:0] exp_seg   = 7'h00;
    logic       exp_dp    = 1'b0;
    logic       exp_blank = 1'b1;

    initial begin
        ev_t e;
        bit  eu, ee;
        forever begin
            @(posedge clk);
            #1;
            eu = 1'b0;
            ee = 1'b0;
            if (rst) begin
                exp_seg   = 7'h00;
                exp_dp    = 1'b0;
                exp_blank = 1'b1;
            end else if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                eu = e.upd;
                ee = e.err;
                exp_seg   = e.seg;
                exp_dp    = e.dp;
                exp_blank = e.blank;
            end
            chk("seg_o", seg_o, exp_seg);
            chk("dp_o", dp_o, exp_dp);
            chk("blank_o", blank_o, exp_blank);
            chk("upd_o", upd_o, eu);
            chk("err_o", err_o, ee);
`ifndef SPI_SEG_READBACK_EN
            chk("spi_miso_tied", bus.spi_miso, 1'b0);
`endif
        end
    end

    // mode: 0 normal, 1 ena low for whole frame, 2 ena drops mid-frame, 3 reset mid-frame
    task automatic send(input logic [31:0] bits, input int n, input int mode, input int gap);
        ev_t e;
        int  lo, hi;
`ifdef SPI_SEG_READBACK_EN
        logic [15:0] rb_exp, rb_got, mask;
        rb_exp = {1'b0, m_blank, 6'b000000, m_dp, m_seg};
        rb_got = '0;
`endif
        @(negedge clk);
        ena = (mode != 1);
        bus.spi_cs_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            if (mode == 2 && i == n / 2)
                ena = 1'b0;
            if (mode == 3 && i == n / 2) begin
                rst = 1'b1;
                #1;
                chk("rst_async_seg", seg_o, 7'h00);
                chk("rst_async_dp", dp_o, 1'b0);
                chk("rst_async_blank", blank_o, 1'b1);
                chk("rst_async_upd", upd_o, 1'b0);
                chk("rst_async_err", err_o, 1'b0);
                m_seg   = 7'h00;
                m_dp    = 1'b0;
                m_blank = 1'b1;
                break;
            end
            bus.spi_mosi = bits[n-1-i];
            lo = $urandom_range(3, 5);
            repeat (lo) @(negedge clk);
`ifdef SPI_SEG_READBACK_EN
            if (i < 16)
                rb_got[15-i] = bus.spi_miso;
`endif
            bus.spi_sclk = 1'b1;
            hi = $urandom_range(3, 5);
            repeat (hi) @(negedge clk);
            bus.spi_sclk = 1'b0;
        end
        if (mode == 3) begin
            repeat (2) @(negedge clk);
            bus.spi_cs_n = 1'b1;
            bus.spi_sclk = 1'b0;
            rst = 1'b0;
        end else begin
            repeat (3) @(negedge clk);
            bus.spi_cs_n = 1'b1;
            if (mode == 0) begin
                // cs_n captured at the next edge, outputs registered three edges later
                e.cyc = cyc + 4;
                e.upd = 1'b0;
                e.err = 1'b0;
                if (n != 16) begin
                    e.err = 1'b1;
                end else begin
                    case (bits[15:8])
                        8'h01: begin m_seg = bits[6:0]; m_dp = bits[7]; e.upd = 1'b1; end
                        8'h02: begin m_blank = bits[0]; e.upd = 1'b1; end
                        8'h03: begin m_seg = 7'h00; m_dp = 1'b0; m_blank = 1'b1; e.upd = 1'b1; end
                        default: e.err = 1'b1;
                    endcase
                end
                e.seg   = m_seg;
                e.dp    = m_dp;
                e.blank = m_blank;
                q.push_back(e);
`ifdef SPI_SEG_READBACK_EN
                mask = (n >= 16) ? 16'hFFFF : (16'hFFFF << (16 - n));
                chk("readback_bits", rb_got & mask, rb_exp & mask);
                rb_last = rb_got;
`endif
            end
            ena = 1'b1;
        end
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        logic [7:0] cmd;
        int         n, mode, sel;
        rst = 1'b1;
        ena = 1'b1;
        bus.spi_cs_n = 1'b1;
        bus.spi_sclk = 1'b0;
        bus.spi_mosi = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_seg", seg_o, 7'h00);
        chk("reset_dp", dp_o, 1'b0);
        chk("reset_blank", blank_o, 1'b1);
        chk("reset_upd", upd_o, 1'b0);
        chk("reset_err", err_o, 1'b0);
        chk("reset_miso", bus.spi_miso, 1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        send(32'h0149, 16, 3, 6);
        send(32'h0149, 16, 0, 6);
        chk("seg_0149", seg_o, 7'h49);
        chk("dp_0149", dp_o, 1'b0);
        send(32'h0200, 16, 0, 6);
        chk("blank_0200", blank_o, 1'b0);
        send(32'h01FF, 16, 0, 6);
        chk("seg_01FF", seg_o, 7'h7F);
        chk("dp_01FF", dp_o, 1'b1);
        send(32'h0300, 16, 0, 6);
        chk("seg_0300", seg_o, 7'h00);
        chk("dp_0300", dp_o, 1'b0);
        chk("blank_0300", blank_o, 1'b1);

        send(32'h01C9, 16, 0, 6);
        send(32'h0200, 16, 0, 6);
        send(32'h7E00, 16, 0, 6);
`ifdef SPI_SEG_READBACK_EN
        chk("readback_00C9", rb_last, 16'h00C9);
`endif
        chk("seg_after_7E", seg_o, 7'h49);
        chk("dp_after_7E", dp_o, 1'b1);
        send(32'h00AA, 15, 0, 6);
        send(32'h002AA, 17, 0, 6);
        chk("seg_after_len_err", seg_o, 7'h49);
        send(32'h0155, 16, 1, 6);
        send(32'h0155, 16, 2, 6);
        chk("seg_after_ena_low", seg_o, 7'h49);

        send(32'h0112, 16, 0, 4);
        send(32'h0134, 16, 0, 4);
        chk("seg_back_to_back", seg_o, 7'h34);

        for (int k = 0; k < 40; k++) begin
            sel = $urandom_range(0, 3);
            cmd = (sel == 3) ? 8'($urandom) : 8'(sel + 1);
            sel = $urandom_range(0, 9);
            n = (sel == 0) ? 15 : (sel == 1) ? 17 : 16;
            sel = $urandom_range(0, 11);
            mode = (sel < 9) ? 0 : sel - 8;
            send({16'h0000, cmd, 8'($urandom)} >> (16 - n), n, mode, $urandom_range(4, 8));
        end

        repeat (10) @(negedge clk);
        chk("events_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
